// File: rtl/sha_link_pkg.sv
// Shared types and constants for the SHA result link toward the host UART.
package sha_link_pkg;

   typedef enum logic [2:0] {
      IDLE,
      TAKE,
      START,
      DATA,
      STOP,
      GAP
   } tx_state_t;

   localparam int UART_DATA_BITS      = 8;
   localparam int RESULT_PACKET_BYTES = 8;

   // Ceiling log2, never below 1 so a counter always has at least one bit.
   function automatic int clog2(input int value);
      int width;
      width = 1;
      while ((1 << width) < value) width++;
      return width;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period tick generator: one-cycle pulse every BAUD_DIV cycles,
// phase-aligned to the most recent restart.
module uart_baud_gen
   import sha_link_pkg::*;
#(
   parameter int BAUD_DIV = 434
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic tick
);

   localparam int CW = clog2(BAUD_DIV);
   localparam logic [CW-1:0] RELOAD = CW'(BAUD_DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q - CW'(1);
      if (restart || (cnt_q == '0)) begin
         cnt_d = RELOAD;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = (cnt_q == '0) && !restart;

endmodule

// File: rtl/result_uart_tx.sv
// Drains result bytes from the job controller and serialises each one as a
// UART frame, with an idle gap after every packet for host resynchronisation.
module result_uart_tx
   import sha_link_pkg::*;
#(
   parameter int BAUD_DIV     = 434,
   parameter int STOP_BITS    = 1,
   parameter int PACKET_BYTES = RESULT_PACKET_BYTES,
   parameter int GAP_BITS     = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       byte_avail,
   input  logic [7:0] byte_in,
   output logic       byte_take,
   output logic       tx,
   output logic       busy,
   output logic [2:0] byte_idx
);

   localparam int GAP_CYCLES = GAP_BITS * BAUD_DIV;
   localparam int GW         = clog2(GAP_CYCLES + 1);
   localparam logic [GW-1:0] GAP_LOAD  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [2:0]    LAST_BIT  = 3'(UART_DATA_BITS - 1);
   localparam logic [2:0]    LAST_IDX  = 3'(PACKET_BYTES - 1);
   localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

   tx_state_t     state_q, state_d;
   logic          tx_q, tx_d;
   logic          take_q, take_d;
   logic          busy_q, busy_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    shreg_q, shreg_d;
   logic [2:0]    bit_q, bit_d;
   logic          stop_q, stop_d;
   logic [GW-1:0] gap_q, gap_d;
   logic          baud_restart;
   logic          baud_tick;

   uart_baud_gen #(
      .BAUD_DIV(BAUD_DIV)
   ) u_baud (
      .clk    (clk),
      .rst    (rst),
      .restart(baud_restart),
      .tick   (baud_tick)
   );

   always_comb begin
      state_d      = state_q;
      tx_d         = tx_q;
      take_d       = 1'b0;
      idx_d        = idx_q;
      shreg_d      = shreg_q;
      bit_d        = bit_q;
      stop_d       = stop_q;
      gap_d        = gap_q;
      baud_restart = 1'b0;

      case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (byte_avail) begin
               state_d = TAKE;
               take_d  = 1'b1;
            end
         end
         TAKE: begin
            // A byte withdrawn during the strobe is dropped without a frame.
            if (byte_avail) begin
               shreg_d      = byte_in;
               state_d      = START;
               tx_d         = 1'b0;
               baud_restart = 1'b1;
            end else begin
               state_d = IDLE;
               tx_d    = 1'b1;
            end
         end
         START: begin
            if (baud_tick) begin
               state_d = DATA;
               tx_d    = shreg_q[0];
               bit_d   = '0;
            end
         end
         DATA: begin
            if (baud_tick) begin
               if (bit_q == LAST_BIT) begin
                  state_d = STOP;
                  tx_d    = 1'b1;
                  bit_d   = '0;
                  stop_d  = 1'b0;
               end else begin
                  shreg_d = {1'b0, shreg_q[7:1]};
                  tx_d    = shreg_q[1];
                  bit_d   = bit_q + 3'd1;
               end
            end
         end
         STOP: begin
            tx_d = 1'b1;
            if (baud_tick) begin
               if (stop_q == LAST_STOP) begin
                  if (idx_q < LAST_IDX) begin
                     idx_d   = idx_q + 3'd1;
                     state_d = IDLE;
                  end else begin
                     idx_d = '0;
                     if (GAP_BITS == 0) begin
                        state_d = IDLE;
                     end else begin
                        state_d = GAP;
                        gap_d   = GAP_LOAD;
                     end
                  end
               end else begin
                  stop_d = 1'b1;
               end
            end
         end
         GAP: begin
            tx_d = 1'b1;
            if (gap_q == '0) begin
               state_d = IDLE;
            end else begin
               gap_d = gap_q - GW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         tx_q    <= 1'b1;
         take_q  <= 1'b0;
         busy_q  <= 1'b0;
         idx_q   <= '0;
         shreg_q <= '0;
         bit_q   <= '0;
         stop_q  <= 1'b0;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         tx_q    <= tx_d;
         take_q  <= take_d;
         busy_q  <= busy_d;
         idx_q   <= idx_d;
         shreg_q <= shreg_d;
         bit_q   <= bit_d;
         stop_q  <= stop_d;
         gap_q   <= gap_d;
      end
   end

   assign tx        = tx_q;
   assign byte_take = take_q;
   assign busy      = busy_q;
   assign byte_idx  = idx_q;

endmodule
